set_assoc_cache: RTL and testbench

//  Parametrised N-way set-associative, write-back, write-allocate cache between CPU and memory.

---
 rtl/cache_pkg.sv | 21 ++
 rtl/cache_plru.sv | 61 ++++++
 rtl/set_assoc_cache.sv | 243 ++++++++++++++++++++++++
 tb/tb_set_assoc_cache.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE_TAG,
    WRITE_BACK,
    ALLOCATE
  } state_e;

  // Byte-offset bits needed to address inside one line.
  function automatic int unsigned line_off_bits(input int unsigned words, input int unsigned word_w);
    return $clog2((words * word_w) / 8);
  endfunction

  // Word-select width, never narrower than one bit so single-word lines stay legal.
  function automatic int unsigned word_sel_bits(input int unsigned words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/cache_plru.sv
// Per-set tree-PLRU state: records the way last accessed and names the way to replace.
module cache_plru
  import cache_pkg::*;
#(
  parameter int unsigned SETS = 256,
  parameter int unsigned WAYS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [$clog2(SETS)-1:0]   idx,
  input  logic                      upd_en,
  input  logic [$clog2(WAYS)-1:0]   upd_way,
  output logic [$clog2(WAYS)-1:0]   victim_way
);

  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned NODES = WAYS - 1;

  logic [NODES-1:0] plru_q [SETS];
  logic [NODES-1:0] row;
  logic [NODES-1:0] row_d;

  assign row = plru_q[idx];

  // Each node bit points toward the colder half; follow the bits to a leaf.
  always_comb begin : victim_walk
    int node;
    node       = 0;
    victim_way = '0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      for (int n = 0; n < int'(NODES); n++) begin
        if (n == node) victim_way[WAY_W-1-l] = row[n];
      end
      node = 2 * node + 1 + int'(victim_way[WAY_W-1-l]);
    end
  end

  // On access, flip every node on the path to point away from the used way.
  always_comb begin : update_walk
    int   node;
    logic dir;
    row_d = row;
    node  = 0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      dir = upd_way[WAY_W-1-l];
      for (int n = 0; n < int'(NODES); n++) begin
        if (n == node) row_d[n] = ~dir;
      end
      node = 2 * node + 1 + int'(dir);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SETS); s++) plru_q[s] <= '0;
    end else if (upd_en) begin
      plru_q[idx] <= row_d;
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back/write-allocate cache with tree-PLRU replacement.
// Optional CACHE_STATS_EN adds hit_count/miss_count outputs.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned WORD_W         = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned SETS           = 256,
  parameter int unsigned WAYS           = 2
) (
  input  logic                             clk,
  input  logic                             r,
  input  logic                             cpu2cache_valid,
  input  logic                             cpu2cache_rw,
  input  logic [ADDR_W-1:0]                cpu2cache_addr,
  input  logic [WORD_W-1:0]                cpu2cache_data,
  output logic [WORD_W-1:0]                cache2cpu_data,
  output logic                             cache2cpu_ready,
  output logic                             cache2mem_valid,
  output logic                             cache2mem_rw,
  output logic [ADDR_W-1:0]                cache2mem_addr,
  output logic [WORDS_PER_LINE*WORD_W-1:0] cache2mem_data,
`ifdef CACHE_STATS_EN
  output logic [31:0]                      hit_count,
  output logic [31:0]                      miss_count,
`endif
  input  logic [WORDS_PER_LINE*WORD_W-1:0] mem2cache_data,
  input  logic                             mem2cache_ready
);

  localparam int unsigned LINE_W = WORDS_PER_LINE * WORD_W;
  localparam int unsigned OFF_W  = line_off_bits(WORDS_PER_LINE, WORD_W);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int unsigned WAY_W  = $clog2(WAYS);
  localparam int unsigned BYTE_W = $clog2(WORD_W / 8);
  localparam int unsigned WSEL_W = word_sel_bits(WORDS_PER_LINE);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic                req_rw_q, req_rw_d;
  logic [WORD_W-1:0]   req_data_q, req_data_d;
  logic [WAY_W-1:0]    victim_q, victim_d;
  logic                refill_q, refill_d;

  logic [TAG_W-1:0]    tag_q  [WAYS][SETS];
  logic [LINE_W-1:0]   line_q [WAYS][SETS];
  logic [SETS-1:0]     valid_q [WAYS];
  logic [SETS-1:0]     dirty_q [WAYS];

  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [WSEL_W-1:0]   req_wsel;
  logic                hit, has_inv;
  logic [WAY_W-1:0]    hit_way, inv_way, plru_victim, victim_c;
  logic [LINE_W-1:0]   hit_line, wr_line;
  logic [WORD_W-1:0]   rd_word;
  logic                in_cmp, wr_hit, fill_done;

  assign req_idx  = req_addr_q[OFF_W +: IDX_W];
  assign req_tag  = req_addr_q[ADDR_W-1 -: TAG_W];
  assign req_wsel = WSEL_W'(req_addr_q >> BYTE_W) & WSEL_W'(WORDS_PER_LINE - 1);

  // Tag match across ways; descending scan leaves the lowest invalid way.
  always_comb begin : lookup
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[w][req_idx]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign hit_line = line_q[hit_way][req_idx];
  assign victim_c = has_inv ? inv_way : plru_victim;

  always_comb begin : word_path
    rd_word = '0;
    wr_line = hit_line;
    for (int k = 0; k < int'(WORDS_PER_LINE); k++) begin
      if (req_wsel == WSEL_W'(k)) begin
        rd_word                      = hit_line[k*WORD_W +: WORD_W];
        wr_line[k*WORD_W +: WORD_W]  = req_data_q;
      end
    end
  end

  assign in_cmp    = (state_q == COMPARE_TAG) && r;
  assign wr_hit    = in_cmp && hit && req_rw_q;
  assign fill_done = (state_q == ALLOCATE) && mem2cache_ready && r;

  cache_plru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_plru (
    .clk        (clk),
    .rst_n      (r),
    .idx        (req_idx),
    .upd_en     (in_cmp && hit),
    .upd_way    (hit_way),
    .victim_way (plru_victim)
  );

  always_comb begin : next_state
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_rw_d   = req_rw_q;
    req_data_d = req_data_q;
    victim_d   = victim_q;
    refill_d   = refill_q;
    case (state_q)
      IDLE: begin
        if (cpu2cache_valid) begin
          req_addr_d = cpu2cache_addr;
          req_rw_d   = cpu2cache_rw;
          req_data_d = cpu2cache_data;
          state_d    = COMPARE_TAG;
        end
      end
      COMPARE_TAG: begin
        refill_d = 1'b0;
        if (hit) begin
          state_d = IDLE;
        end else begin
          victim_d = victim_c;
          state_d  = dirty_q[victim_c][req_idx] ? WRITE_BACK : ALLOCATE;
        end
      end
      WRITE_BACK: if (mem2cache_ready) state_d = ALLOCATE;
      ALLOCATE: begin
        if (mem2cache_ready) begin
          state_d  = COMPARE_TAG;
          refill_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : ctrl_regs
    if (!r) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      req_rw_q   <= 1'b0;
      req_data_q <= '0;
      victim_q   <= '0;
      refill_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      req_rw_q   <= req_rw_d;
      req_data_q <= req_data_d;
      victim_q   <= victim_d;
      refill_q   <= refill_d;
    end
  end

  always_ff @(posedge clk) begin : status_regs
    if (!r) begin
      for (int w = 0; w < int'(WAYS); w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
    end else begin
      if (fill_done) begin
        valid_q[victim_q][req_idx] <= 1'b1;
        dirty_q[victim_q][req_idx] <= 1'b0;
      end
      if (wr_hit) dirty_q[hit_way][req_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin : array_regs
    if (wr_hit) line_q[hit_way][req_idx] <= wr_line;
    if (fill_done) begin
      line_q[victim_q][req_idx] <= mem2cache_data;
      tag_q[victim_q][req_idx]  <= req_tag;
    end
  end

  assign cache2cpu_ready = (state_q == COMPARE_TAG) && hit;
  assign cache2cpu_data  = cache2cpu_ready ? rd_word : '0;

  // Memory side is a pure function of state and latched request, so it is stable while valid.
  always_comb begin : mem_if
    cache2mem_valid = 1'b0;
    cache2mem_rw    = 1'b0;
    cache2mem_addr  = '0;
    cache2mem_data  = '0;
    case (state_q)
      WRITE_BACK: begin
        cache2mem_valid = 1'b1;
        cache2mem_rw    = 1'b1;
        cache2mem_addr  = {tag_q[victim_q][req_idx], req_idx, {OFF_W{1'b0}}};
        cache2mem_data  = line_q[victim_q][req_idx];
      end
      ALLOCATE: begin
        cache2mem_valid = 1'b1;
        cache2mem_addr  = {req_tag, req_idx, {OFF_W{1'b0}}};
      end
      default: ;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // The compare that follows a refill is a guaranteed hit and is not counted.
  always_comb begin : stats_next
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (in_cmp && !refill_q) begin
      if (hit) hit_count_d  = hit_count_q + 32'd1;
      else     miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin : stats_regs
    if (!r) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Self-checking bench for set_assoc_cache (2-way, 256 sets, 4-word lines) against an LRU line model.
module tb_set_assoc_cache;

  logic         clk;
  logic         r;
  logic         cpu2cache_valid;
  logic         cpu2cache_rw;
  logic [31:0]  cpu2cache_addr;
  logic [31:0]  cpu2cache_data;
  logic [31:0]  cache2cpu_data;
  logic         cache2cpu_ready;
  logic         cache2mem_valid;
  logic         cache2mem_rw;
  logic [31:0]  cache2mem_addr;
  logic [127:0] cache2mem_data;
  logic [127:0] mem2cache_data;
  logic         mem2cache_ready;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  set_assoc_cache dut (
    .clk             (clk),
    .r               (r),
    .cpu2cache_valid (cpu2cache_valid),
    .cpu2cache_rw    (cpu2cache_rw),
    .cpu2cache_addr  (cpu2cache_addr),
    .cpu2cache_data  (cpu2cache_data),
    .cache2cpu_data  (cache2cpu_data),
    .cache2cpu_ready (cache2cpu_ready),
    .cache2mem_valid (cache2mem_valid),
    .cache2mem_rw    (cache2mem_rw),
    .cache2mem_addr  (cache2mem_addr),
    .cache2mem_data  (cache2mem_data),
`ifdef CACHE_STATS_EN
    .hit_count       (hit_count),
    .miss_count      (miss_count),
`endif
    .mem2cache_data  (mem2cache_data),
    .mem2cache_ready (mem2cache_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: per set two lines, plus which way was touched last.
  bit           mvalid [2][256];
  bit           mdirty [2][256];
  logic [19:0]  mtag   [2][256];
  logic [127:0] mdata  [2][256];
  int           mru    [256];
  logic [127:0] mem    [logic [31:0]];
  int           m_hits;
  int           m_misses;

  // Observations from the most recent access, for literal expectations.
  logic         got_first;
  logic [31:0]  got_data;
  bit           got_wb;
  logic [31:0]  got_wb_addr;
  logic [127:0] got_wb_line;
  logic [31:0]  got_fill_addr;

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0b expected %0b at %0t", name, got, exp, $time);
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
  endtask

  task automatic chk128(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%032h expected 0x%032h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a ^ 32'h5A5A_5A5A, ~a, a + 32'h0000_0100, a ^ 32'hC0DE_0000};
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 256; s++) begin
        mvalid[w][s] = 1'b0;
        mdirty[w][s] = 1'b0;
      end
    for (int s = 0; s < 256; s++) mru[s] = 0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic scramble_cpu();
    cpu2cache_valid = 1'($urandom_range(0, 1));
    cpu2cache_rw    = 1'($urandom_range(0, 1));
    cpu2cache_addr  = $urandom();
    cpu2cache_data  = $urandom();
  endtask

  // One CPU access, checked on every cycle from capture through completion.
  task automatic run_access(input bit rw, input logic [31:0] addr, input logic [31:0] wdata);
    logic [7:0]   idx;
    logic [19:0]  tag;
    int           wo, way, v, lat;
    bit           hit, wb;
    logic [31:0]  wb_a, fill_a, exp_rd;
    logic [127:0] wb_l, fill_l;
    idx    = addr[11:4];
    tag    = addr[31:12];
    wo     = int'(addr[3:2]);
    hit    = 1'b0;
    way    = 0;
    v      = 0;
    wb     = 1'b0;
    wb_a   = '0;
    wb_l   = '0;
    fill_l = '0;
    fill_a = {addr[31:4], 4'h0};
    for (int w = 0; w < 2; w++)
      if (mvalid[w][idx] && mtag[w][idx] == tag) begin
        hit = 1'b1;
        way = w;
      end
    if (!hit) begin
      if (!mvalid[0][idx])      v = 0;
      else if (!mvalid[1][idx]) v = 1;
      else                      v = 1 - mru[idx];
      wb     = mvalid[v][idx] && mdirty[v][idx];
      wb_a   = {mtag[v][idx], idx, 4'h0};
      wb_l   = mdata[v][idx];
      if (wb) mem[wb_a] = wb_l;
      fill_l = mem_line(fill_a);
      mvalid[v][idx] = 1'b1;
      mdirty[v][idx] = 1'b0;
      mtag[v][idx]   = tag;
      mdata[v][idx]  = fill_l;
      way = v;
      m_misses++;
    end else begin
      m_hits++;
    end
    mru[idx] = way;
    exp_rd   = mdata[way][idx][wo*32 +: 32];
    if (rw) begin
      mdata[way][idx][wo*32 +: 32] = wdata;
      mdirty[way][idx] = 1'b1;
    end
    got_wb = 1'b0;

    @(negedge clk);
    chk1("idle_ready", cache2cpu_ready, 1'b0);
    chk1("idle_mem_valid", cache2mem_valid, 1'b0);
    cpu2cache_valid = 1'b1;
    cpu2cache_rw    = rw;
    cpu2cache_addr  = addr;
    cpu2cache_data  = wdata;
    mem2cache_ready = 1'($urandom_range(0, 1));
    mem2cache_data  = {$urandom(), $urandom(), $urandom(), $urandom()};

    @(negedge clk);
    scramble_cpu();
    mem2cache_ready = 1'($urandom_range(0, 1));
    got_first = cache2cpu_ready;
    chk1("compare_ready", cache2cpu_ready, hit);
    chk1("compare_mem_valid", cache2mem_valid, 1'b0);
    if (hit) begin
      got_data = cache2cpu_data;
      if (!rw) chk32("hit_data", cache2cpu_data, exp_rd);
    end else begin
      if (wb) begin
        lat = $urandom_range(0, 3);
        for (int k = 0; k <= lat; k++) begin
          @(negedge clk);
          mem2cache_ready = 1'b0;
          scramble_cpu();
          chk1("wb_valid", cache2mem_valid, 1'b1);
          chk1("wb_rw", cache2mem_rw, 1'b1);
          chk32("wb_addr", cache2mem_addr, wb_a);
          chk128("wb_data", cache2mem_data, wb_l);
          chk1("wb_ready_low", cache2cpu_ready, 1'b0);
          if (k == lat) begin
            got_wb          = 1'b1;
            got_wb_addr     = cache2mem_addr;
            got_wb_line     = cache2mem_data;
            mem2cache_ready = 1'b1;
            mem2cache_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
          end
        end
      end
      lat = $urandom_range(0, 3);
      for (int k = 0; k <= lat; k++) begin
        @(negedge clk);
        mem2cache_ready = 1'b0;
        scramble_cpu();
        chk1("fill_valid", cache2mem_valid, 1'b1);
        chk1("fill_rw", cache2mem_rw, 1'b0);
        chk32("fill_addr", cache2mem_addr, fill_a);
        chk1("fill_ready_low", cache2cpu_ready, 1'b0);
        if (k == lat) begin
          got_fill_addr   = cache2mem_addr;
          mem2cache_ready = 1'b1;
          mem2cache_data  = fill_l;
        end
      end
      @(negedge clk);
      mem2cache_ready = 1'($urandom_range(0, 1));
      mem2cache_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      chk1("refill_ready", cache2cpu_ready, 1'b1);
      chk1("refill_mem_valid", cache2mem_valid, 1'b0);
      got_data = cache2cpu_data;
      if (!rw) chk32("refill_data", cache2cpu_data, exp_rd);
    end
    cpu2cache_valid = 1'b0;
    mem2cache_ready = 1'b0;
`ifdef CACHE_STATS_EN
    @(negedge clk);
    chk32("hit_count", hit_count, 32'(m_hits));
    chk32("miss_count", miss_count, 32'(m_misses));
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ridx;
    r               = 1'b0;
    cpu2cache_valid = 1'b0;
    cpu2cache_rw    = 1'b0;
    cpu2cache_addr  = '0;
    cpu2cache_data  = '0;
    mem2cache_ready = 1'b0;
    mem2cache_data  = '0;
    model_reset();
    mem[32'h0000_1230] = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};

    repeat (2) @(negedge clk);
    chk1("rst_ready", cache2cpu_ready, 1'b0);
    chk32("rst_cpu_data", cache2cpu_data, 32'h0);
    chk1("rst_mem_valid", cache2mem_valid, 1'b0);
    chk1("rst_mem_rw", cache2mem_rw, 1'b0);
    chk32("rst_mem_addr", cache2mem_addr, 32'h0);
    chk128("rst_mem_data", cache2mem_data, 128'h0);
`ifdef CACHE_STATS_EN
    chk32("rst_hit_count", hit_count, 32'h0);
    chk32("rst_miss_count", miss_count, 32'h0);
`endif
    r = 1'b1;

    run_access(1'b0, 32'h0000_1230, 32'h0);
    chk1("s1_miss", got_first, 1'b0);
    chk32("s1_fill_addr", got_fill_addr, 32'h0000_1230);
    chk32("s1_data", got_data, 32'hDEAD_BEEF);

    run_access(1'b0, 32'h0000_1230, 32'h0);
    chk1("s2_hit", got_first, 1'b1);
    chk32("s2_data", got_data, 32'hDEAD_BEEF);

    run_access(1'b1, 32'h0000_1234, 32'h1234_5678);
    chk1("s3_write_hit", got_first, 1'b1);
    run_access(1'b0, 32'h0000_1234, 32'h0);
    chk32("s3_read_back", got_data, 32'h1234_5678);

    run_access(1'b0, 32'h0000_2230, 32'h0);
    chk1("s4_way1_miss", got_first, 1'b0);
    run_access(1'b0, 32'h0000_3230, 32'h0);
    chk1("s4_wb_seen", got_wb, 1'b1);
    chk32("s4_wb_addr", got_wb_addr, 32'h0000_1230);
    chk32("s4_wb_word1", got_wb_line[63:32], 32'h1234_5678);
`ifdef CACHE_STATS_EN
    chk32("s6_hits", hit_count, 32'd3);
    chk32("s6_misses", miss_count, 32'd3);
`endif

    // Reset while a fill is outstanding; the fill response must be dropped.
    @(negedge clk);
    cpu2cache_valid = 1'b1;
    cpu2cache_rw    = 1'b0;
    cpu2cache_addr  = 32'h0000_4230;
    @(negedge clk);
    cpu2cache_valid = 1'b0;
    chk1("s5_miss", cache2cpu_ready, 1'b0);
    @(negedge clk);
    chk1("s5_alloc_valid", cache2mem_valid, 1'b1);
    chk1("s5_alloc_rw", cache2mem_rw, 1'b0);
    chk32("s5_alloc_addr", cache2mem_addr, 32'h0000_4230);
    r               = 1'b0;
    mem2cache_ready = 1'b1;
    mem2cache_data  = '1;
    @(negedge clk);
    r               = 1'b1;
    mem2cache_ready = 1'b0;
    chk1("s5_mem_valid_dropped", cache2mem_valid, 1'b0);
    chk1("s5_ready_low", cache2cpu_ready, 1'b0);
    chk32("s5_mem_addr_clear", cache2mem_addr, 32'h0);
    model_reset();
    run_access(1'b0, 32'h0000_2230, 32'h0);
    chk1("s5_after_reset_miss", got_first, 1'b0);
`ifdef CACHE_STATS_EN
    chk32("s5_hits", hit_count, 32'd0);
    chk32("s5_misses", miss_count, 32'd1);
`endif

    // Random traffic concentrated on a few sets to force conflicts and write-backs.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       ridx = 8'h23;
        1:       ridx = 8'h00;
        2:       ridx = 8'hFF;
        default: ridx = 8'($urandom_range(0, 255));
      endcase
      run_access(1'($urandom_range(0, 1)),
                 {20'($urandom_range(0, 5)), ridx, 2'($urandom_range(0, 3)), 2'b00},
                 $urandom());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
